// File: rtl/muldiv_issue_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_issue_queue_pkg                                           |
// | Brief   : Shared types and constants for the mult/div issue queue.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package muldiv_issue_queue_pkg;

  // Sequencer states for the shared multdiv unit
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } mdState_t;

  // Codes written to the status register when an op raises an exception
  localparam int c_EXC_MULT           = 4;
  localparam int c_EXC_DIV            = 5;
  localparam int c_STATUS_REG_DEFAULT = 30;

  // Exception code for the op type that faulted
  function automatic logic [2:0] excCode(input logic isDiv);
    return isDiv ? 3'(c_EXC_DIV) : 3'(c_EXC_MULT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_issue_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_issue_queue_if                                            |
// | Brief   : Issue, scoreboard, multdiv and writeback signals of the queue.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface muldiv_issue_queue_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // Issue from DX
  logic              issue_valid;
  logic              issue_is_div;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [REG_W-1:0]  issue_rd;
  logic              issue_ready;
  // Decode-stage scoreboard lookup
  logic [REG_W-1:0]  chk_rs;
  logic [REG_W-1:0]  chk_rt;
  logic              chk_hazard;
  // Shared multdiv unit
  logic              md_start_mult;
  logic              md_start_div;
  logic [DATA_W-1:0] md_a;
  logic [DATA_W-1:0] md_b;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_ready;
  // Regfile writeback
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_accept;
  logic              busy;

  // Pipeline / multdiv / regfile side
  modport master (
    output issue_valid, issue_is_div, issue_a, issue_b, issue_rd,
    input  issue_ready,
    output chk_rs, chk_rt,
    input  chk_hazard,
    input  md_start_mult, md_start_div, md_a, md_b,
    output md_result, md_exception, md_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_accept,
    input  busy
  );

  // Issue queue side
  modport slave (
    input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd,
    output issue_ready,
    input  chk_rs, chk_rt,
    output chk_hazard,
    output md_start_mult, md_start_div, md_a, md_b,
    input  md_result, md_exception, md_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_accept,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_issue_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_issue_queue_fifo                                          |
// | Brief   : Circular buffer of pending mult/div ops; exposes the head, the   |
// |           entry behind it and every slot's rd for hazard lookup.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module muldiv_issue_queue_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  parameter  int REG_W  = 5,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pushEn,
  input  logic                        pushIsDiv,
  input  logic [DATA_W-1:0]           pushA,
  input  logic [DATA_W-1:0]           pushB,
  input  logic [REG_W-1:0]            pushRd,
  input  logic                        popEn,
  output logic [CNT_W-1:0]            count,
  output logic                        headIsDiv,
  output logic [DATA_W-1:0]           headA,
  output logic [DATA_W-1:0]           headB,
  output logic [REG_W-1:0]            headRd,
  output logic                        nextIsDiv,
  output logic [DATA_W-1:0]           nextA,
  output logic [DATA_W-1:0]           nextB,
  output logic [DEPTH-1:0]            entryValid,
  output logic [DEPTH-1:0][REG_W-1:0] entryRd
);

  logic              r_isDiv [DEPTH];
  logic [DATA_W-1:0] r_a     [DEPTH];
  logic [DATA_W-1:0] r_b     [DEPTH];
  logic [REG_W-1:0]  r_rd    [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  w_nextPtr;
  logic [CNT_W-1:0]  r_count;

  // Payload storage; contents only matter where entryValid is set
  always_ff @(posedge clock) begin
    if (pushEn) begin
      r_isDiv[r_tail] <= pushIsDiv;
      r_a[r_tail]     <= pushA;
      r_b[r_tail]     <= pushB;
      r_rd[r_tail]    <= pushRd;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (pushEn) r_tail <= r_tail + PTR_W'(1);
      if (popEn)  r_head <= r_head + PTR_W'(1);
      case ({pushEn, popEn})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_nextPtr = r_head + PTR_W'(1);
  assign count     = r_count;
  assign headIsDiv = r_isDiv[r_head];
  assign headA     = r_a[r_head];
  assign headB     = r_b[r_head];
  assign headRd    = r_rd[r_head];
  assign nextIsDiv = r_isDiv[w_nextPtr];
  assign nextA     = r_a[w_nextPtr];
  assign nextB     = r_b[w_nextPtr];

  // A slot is live when its distance from the head is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] w_offset;
    assign w_offset      = PTR_W'(i) - r_head;
    assign entryValid[i] = (CNT_W'(w_offset) < r_count);
    assign entryRd[i]    = r_rd[i];
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_issue_queue                                               |
// | Brief   : Non-blocking issue buffer and scoreboard for mult/div ops; runs  |
// |           them in order on the shared multdiv and retires via the regfile. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module muldiv_issue_queue
  import muldiv_issue_queue_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = c_STATUS_REG_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  muldiv_issue_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                        w_push;
  logic                        w_pop;
  logic [CNT_W-1:0]            w_count;
  logic                        w_headIsDiv;
  logic [DATA_W-1:0]           w_headA;
  logic [DATA_W-1:0]           w_headB;
  logic [REG_W-1:0]            w_headRd;
  logic                        w_nextIsDiv;
  logic [DATA_W-1:0]           w_nextA;
  logic [DATA_W-1:0]           w_nextB;
  logic [DEPTH-1:0]            w_entryValid;
  logic [DEPTH-1:0][REG_W-1:0] w_entryRd;
  logic [DEPTH-1:0]            w_slotHit;
  logic                        w_issueHit;

  mdState_t          r_state,     w_stateNext;
  logic              r_startMult, w_startMultNext;
  logic              r_startDiv,  w_startDivNext;
  logic [DATA_W-1:0] r_mdA,       w_mdANext;
  logic [DATA_W-1:0] r_mdB,       w_mdBNext;
  logic              r_wbValid,   w_wbValidNext;
  logic [REG_W-1:0]  r_wbRd,      w_wbRdNext;
  logic [DATA_W-1:0] r_wbData,    w_wbDataNext;

  // No bypass when full: a retire in the same cycle does not open a slot
  assign bus.issue_ready = (w_count != CNT_W'(DEPTH));
  assign w_push          = bus.issue_valid && bus.issue_ready;

  muldiv_issue_queue_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .pushEn     (w_push),
    .pushIsDiv  (bus.issue_is_div),
    .pushA      (bus.issue_a),
    .pushB      (bus.issue_b),
    .pushRd     (bus.issue_rd),
    .popEn      (w_pop),
    .count      (w_count),
    .headIsDiv  (w_headIsDiv),
    .headA      (w_headA),
    .headB      (w_headB),
    .headRd     (w_headRd),
    .nextIsDiv  (w_nextIsDiv),
    .nextA      (w_nextA),
    .nextB      (w_nextB),
    .entryValid (w_entryValid),
    .entryRd    (w_entryRd)
  );

  // Pending destinations stall decode; r0 is never a hazard
  for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
    assign w_slotHit[i] = w_entryValid[i] && (w_entryRd[i] != '0) &&
                          ((w_entryRd[i] == bus.chk_rs) || (w_entryRd[i] == bus.chk_rt));
  end

  // The op being accepted this cycle is covered too, so there is no gap
  assign w_issueHit = w_push && (bus.issue_rd != '0) &&
                      ((bus.issue_rd == bus.chk_rs) || (bus.issue_rd == bus.chk_rt));
  assign bus.chk_hazard = (|w_slotHit) || w_issueHit;

  // Next-state and next-output logic for the multdiv sequencer
  always_comb begin
    w_stateNext     = r_state;
    w_startMultNext = 1'b0;
    w_startDivNext  = 1'b0;
    w_mdANext       = r_mdA;
    w_mdBNext       = r_mdB;
    w_wbValidNext   = r_wbValid;
    w_wbRdNext      = r_wbRd;
    w_wbDataNext    = r_wbData;
    w_pop           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_count != '0) begin
          w_stateNext     = ST_START;
          w_startMultNext = !w_headIsDiv;
          w_startDivNext  = w_headIsDiv;
          w_mdANext       = w_headA;
          w_mdBNext       = w_headB;
        end
      end
      ST_START: begin
        w_stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.md_ready) begin
          w_stateNext = ST_HOLD;
          if (bus.md_exception) begin
            w_wbValidNext = 1'b1;
            w_wbRdNext    = REG_W'(STATUS_REG);
            w_wbDataNext  = DATA_W'(excCode(w_headIsDiv));
          end else if (w_headRd != '0) begin
            w_wbValidNext = 1'b1;
            w_wbRdNext    = w_headRd;
            w_wbDataNext  = bus.md_result;
          end
        end
      end
      ST_HOLD: begin
        // A silent r0 result drains without waiting for the write port
        if (!r_wbValid || bus.wb_accept) begin
          w_pop         = 1'b1;
          w_wbValidNext = 1'b0;
          if (w_count > CNT_W'(1)) begin
            // The head pops on this edge, so launch the entry behind it
            w_stateNext     = ST_START;
            w_startMultNext = !w_nextIsDiv;
            w_startDivNext  = w_nextIsDiv;
            w_mdANext       = w_nextA;
            w_mdBNext       = w_nextB;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered multdiv / writeback outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_startMult <= 1'b0;
      r_startDiv  <= 1'b0;
      r_mdA       <= '0;
      r_mdB       <= '0;
      r_wbValid   <= 1'b0;
      r_wbRd      <= '0;
      r_wbData    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_startMult <= w_startMultNext;
      r_startDiv  <= w_startDivNext;
      r_mdA       <= w_mdANext;
      r_mdB       <= w_mdBNext;
      r_wbValid   <= w_wbValidNext;
      r_wbRd      <= w_wbRdNext;
      r_wbData    <= w_wbDataNext;
    end
  end

  assign bus.md_start_mult = r_startMult;
  assign bus.md_start_div  = r_startDiv;
  assign bus.md_a          = r_mdA;
  assign bus.md_b          = r_mdB;
  assign bus.wb_valid      = r_wbValid;
  assign bus.wb_rd         = r_wbRd;
  assign bus.wb_data       = r_wbData;
  assign bus.busy          = (w_count != '0) || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_muldiv_issue_queue                                            |
// | Brief   : Directed self-checking bench with a 4-cycle multdiv model.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_muldiv_issue_queue;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clock = 1'b0;
  logic reset;
  logic strayPulse;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clock = ~clock;

  muldiv_issue_queue_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  muldiv_issue_queue #(
    .DEPTH      (4),
    .DATA_W     (DATA_W),
    .REG_W      (REG_W),
    .STATUS_REG (30)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- multdiv model: result 4 cycles after the start pulse ----
  logic [2:0]  mdCnt;
  logic        mdIsDiv;
  logic [31:0] mdOpA, mdOpB;
  logic        mdReadyQ, mdExcQ;
  logic [31:0] mdResQ;

  function automatic logic [32:0] mdCalc(input logic isDiv, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    if (isDiv) begin
      if (b == 32'd0) return {1'b1, 32'd0};
      return {1'b0, a / b};
    end
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {!((p[63:31] == '0) || (p[63:31] == '1)), p[31:0]};
  endfunction

  // Latch operands on start, pulse ready after the countdown
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mdCnt    <= '0;
      mdReadyQ <= 1'b0;
      mdExcQ   <= 1'b0;
      mdResQ   <= '0;
      mdIsDiv  <= 1'b0;
      mdOpA    <= '0;
      mdOpB    <= '0;
    end else begin
      mdReadyQ <= 1'b0;
      if (bus.md_start_mult || bus.md_start_div) begin
        mdCnt   <= 3'd4;
        mdIsDiv <= bus.md_start_div;
        mdOpA   <= bus.md_a;
        mdOpB   <= bus.md_b;
      end else if (mdCnt != 3'd0) begin
        mdCnt <= mdCnt - 3'd1;
        if (mdCnt == 3'd1) begin
          mdReadyQ         <= 1'b1;
          {mdExcQ, mdResQ} <= mdCalc(mdIsDiv, mdOpA, mdOpB);
        end
      end
    end
  end

  assign bus.md_ready     = mdReadyQ | strayPulse;
  assign bus.md_result    = mdResQ;
  assign bus.md_exception = mdExcQ;

  // ---------------- timing helpers ------------------------------------------
  // Drive point: 1 time unit after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From a drive point, wait for wb_valid; returns at a sample point
  task automatic waitWbValid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (bus.wb_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // From a drive point, wait for busy to drop, counting wb_valid cycles
  task automatic waitIdle(input int limit, output bit ok, output int wbSeen);
    ok     = 1'b0;
    wbSeen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (bus.wb_valid) wbSeen++;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic setIssue(input logic isDiv, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.issue_valid  = 1'b1;
    bus.issue_is_div = isDiv;
    bus.issue_a      = a;
    bus.issue_b      = b;
    bus.issue_rd     = rd;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    @(negedge clock);
    nChecks++;
    if (bus.issue_ready !== 1'b1) $display("FAIL rst_issue_ready: got %b want 1", bus.issue_ready);
    else nPass++;
    nChecks++;
    if ({bus.busy, bus.wb_valid, bus.md_start_mult, bus.md_start_div, bus.chk_hazard} !== 5'b0)
      $display("FAIL rst_flags: got %b want 00000",
               {bus.busy, bus.wb_valid, bus.md_start_mult, bus.md_start_div, bus.chk_hazard});
    else nPass++;
    nChecks++;
    if ({bus.md_a, bus.md_b, bus.wb_rd, bus.wb_data} !== 101'b0)
      $display("FAIL rst_regs: got %h/%h/%h/%h want 0", bus.md_a, bus.md_b, bus.wb_rd, bus.wb_data);
    else nPass++;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_mult();
    int   starts = 0;
    bit   seen = 1'b0;
    bit   ok;
    int   wbSeen;
    logic [4:0]  rd = '0;
    logic [31:0] data = '0;
    bus.wb_accept = 1'b1;
    setIssue(1'b0, 32'd6, 32'd7, 5'd3);
    step();
    bus.issue_valid = 1'b0;
    @(negedge clock);
    nChecks++;
    if ({bus.md_start_mult, bus.busy} !== 2'b01)
      $display("FAIL single_pre_start: start/busy got %b want 01", {bus.md_start_mult, bus.busy});
    else nPass++;
    step();
    @(negedge clock);
    nChecks++;
    if ({bus.md_start_mult, bus.md_start_div, bus.md_a, bus.md_b} !== {2'b10, 32'd6, 32'd7})
      $display("FAIL single_start: got %b%b a=%0d b=%0d want 10 a=6 b=7",
               bus.md_start_mult, bus.md_start_div, bus.md_a, bus.md_b);
    else nPass++;
    starts = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      @(negedge clock);
      if (bus.md_start_mult || bus.md_start_div) starts++;
      if (bus.wb_valid) begin
        seen = 1'b1;
        rd   = bus.wb_rd;
        data = bus.wb_data;
      end
    end
    nChecks++;
    if (!seen) $display("FAIL single_wb_timeout: wb_valid got 0 want 1");
    else nPass++;
    nChecks++;
    if (starts !== 1) $display("FAIL single_start_count: got %0d want 1", starts);
    else nPass++;
    nChecks++;
    if ({rd, data} !== {5'd3, 32'd42}) $display("FAIL single_result: got rd=%0d data=%0d want rd=3 data=42", rd, data);
    else nPass++;
    step();
    @(negedge clock);
    nChecks++;
    if ({bus.wb_valid, bus.busy} !== 2'b00)
      $display("FAIL single_after_retire: wb_valid/busy got %b want 00", {bus.wb_valid, bus.busy});
    else nPass++;
    step();
    waitIdle(5, ok, wbSeen);
    step();
  endtask

  task automatic test_back_to_back();
    int   retired = 0;
    int   readyAt = -1;
    int   consec  = 0;
    bit   longStart = 1'b0;
    bit   acceptNext = 1'b0;
    bit   ok;
    int   wbSeen;
    logic [4:0]  expRd;
    logic [31:0] expData;
    bus.wb_accept = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      setIssue(1'b0, 32'(k), 32'd10, 5'(k));
      step();
    end
    setIssue(1'b0, 32'd5, 32'd10, 5'd5);
    @(negedge clock);
    nChecks++;
    if (bus.issue_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", bus.issue_ready);
    else nPass++;
    step();
    for (int i = 0; i < 150 && retired < 5; i++) begin
      @(negedge clock);
      if (bus.md_start_mult || bus.md_start_div) begin
        consec++;
        if (consec > 1) longStart = 1'b1;
      end else begin
        consec = 0;
      end
      if (bus.issue_valid && bus.issue_ready) begin
        readyAt    = retired;
        acceptNext = 1'b1;
      end
      if (bus.wb_valid) begin
        expRd   = 5'(retired + 1);
        expData = 32'((retired + 1) * 10);
        nChecks++;
        if ({bus.wb_rd, bus.wb_data} !== {expRd, expData})
          $display("FAIL b2b_retire_order: got rd=%0d data=%0d want rd=%0d data=%0d",
                   bus.wb_rd, bus.wb_data, expRd, expData);
        else nPass++;
        retired++;
      end
      step();
      if (acceptNext) begin
        bus.issue_valid = 1'b0;
        acceptNext      = 1'b0;
      end
    end
    nChecks++;
    if (retired !== 5) $display("FAIL b2b_retire_count: got %0d want 5", retired);
    else nPass++;
    nChecks++;
    if (readyAt !== 1) $display("FAIL b2b_fifth_held: accepted after %0d retires want 1", readyAt);
    else nPass++;
    nChecks++;
    if (longStart !== 1'b0) $display("FAIL b2b_start_width: multi-cycle start got 1 want 0");
    else nPass++;
    waitIdle(20, ok, wbSeen);
    step();
  endtask

  task automatic test_hazard();
    bit ok;
    int wbSeen;
    bus.wb_accept = 1'b0;
    setIssue(1'b0, 32'd3, 32'd4, 5'd2);
    step();
    bus.issue_valid = 1'b0;
    bus.chk_rs      = 5'd2;
    @(negedge clock);
    nChecks++;
    if (bus.chk_hazard !== 1'b1) $display("FAIL haz_pending: got %b want 1", bus.chk_hazard);
    else nPass++;
    step();
    waitWbValid(30, ok);
    nChecks++;
    if (!ok || bus.chk_hazard !== 1'b1) $display("FAIL haz_hold: wb_valid=%b hazard=%b want 1 1", ok, bus.chk_hazard);
    else nPass++;
    step();
    bus.wb_accept = 1'b1;
    @(negedge clock);
    nChecks++;
    if ({bus.chk_hazard, bus.wb_valid} !== 2'b11)
      $display("FAIL haz_retire_cycle: hazard/wb_valid got %b want 11", {bus.chk_hazard, bus.wb_valid});
    else nPass++;
    step();
    @(negedge clock);
    nChecks++;
    if (bus.chk_hazard !== 1'b0) $display("FAIL haz_cleared: got %b want 0", bus.chk_hazard);
    else nPass++;
    step();
    bus.chk_rs = 5'd0;

    // Same-cycle issue compare
    setIssue(1'b0, 32'd1, 32'd1, 5'd5);
    bus.chk_rt = 5'd6;
    #1;
    nChecks++;
    if (bus.chk_hazard !== 1'b0) $display("FAIL haz_no_match: got %b want 0", bus.chk_hazard);
    else nPass++;
    bus.chk_rt = 5'd5;
    #1;
    nChecks++;
    if (bus.chk_hazard !== 1'b1) $display("FAIL haz_same_cycle: got %b want 1", bus.chk_hazard);
    else nPass++;
    step();
    bus.issue_valid = 1'b0;
    bus.chk_rt      = 5'd0;
    waitIdle(30, ok, wbSeen);
    step();

    // r0 never hazards and retires silently
    setIssue(1'b0, 32'd1, 32'd1, 5'd0);
    #1;
    nChecks++;
    if (bus.chk_hazard !== 1'b0) $display("FAIL haz_r0_issue: got %b want 0", bus.chk_hazard);
    else nPass++;
    step();
    bus.issue_valid = 1'b0;
    @(negedge clock);
    nChecks++;
    if ({bus.chk_hazard, bus.busy} !== 2'b01)
      $display("FAIL haz_r0_pending: hazard/busy got %b want 01", {bus.chk_hazard, bus.busy});
    else nPass++;
    step();
    waitIdle(30, ok, wbSeen);
    nChecks++;
    if (!ok || wbSeen !== 0) $display("FAIL r0_silent_retire: idle=%b wb_cycles=%0d want 1 0", ok, wbSeen);
    else nPass++;
    step();
  endtask

  task automatic test_exception();
    bit ok;
    int wbSeen;
    bus.wb_accept = 1'b1;
    setIssue(1'b1, 32'd10, 32'd0, 5'd7);
    step();
    bus.issue_valid = 1'b0;
    waitWbValid(30, ok);
    nChecks++;
    if (!ok || {bus.wb_rd, bus.wb_data} !== {5'd30, 32'd5})
      $display("FAIL exc_div0: got valid=%b rd=%0d data=%0d want 1 30 5", ok, bus.wb_rd, bus.wb_data);
    else nPass++;
    step();
    waitIdle(10, ok, wbSeen);
    step();
    setIssue(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd8);
    step();
    bus.issue_valid = 1'b0;
    waitWbValid(30, ok);
    nChecks++;
    if (!ok || {bus.wb_rd, bus.wb_data} !== {5'd30, 32'd4})
      $display("FAIL exc_mult_ovf: got valid=%b rd=%0d data=%0d want 1 30 4", ok, bus.wb_rd, bus.wb_data);
    else nPass++;
    step();
    waitIdle(10, ok, wbSeen);
    step();
  endtask

  task automatic test_hold_stable();
    bit ok;
    int wbSeen;
    logic [39:0] act;
    bus.wb_accept = 1'b0;
    setIssue(1'b0, 32'd2, 32'd3, 5'd8);
    step();
    setIssue(1'b0, 32'd4, 32'd5, 5'd9);
    step();
    bus.issue_valid = 1'b0;
    waitWbValid(30, ok);
    nChecks++;
    if (!ok) $display("FAIL hold_reached: wb_valid got 0 want 1");
    else nPass++;
    for (int k = 0; k < 5; k++) begin
      act = {bus.wb_valid, bus.wb_rd, bus.wb_data, bus.md_start_mult, bus.md_start_div};
      nChecks++;
      if (act !== {1'b1, 5'd8, 32'd6, 2'b00})
        $display("FAIL hold_stable[%0d]: got %h want %h", k, act, {1'b1, 5'd8, 32'd6, 2'b00});
      else nPass++;
      step();
      if (k == 4) bus.wb_accept = 1'b1;
      @(negedge clock);
    end
    nChecks++;
    if (bus.wb_valid !== 1'b1) $display("FAIL hold_sixth_cycle: wb_valid got %b want 1", bus.wb_valid);
    else nPass++;
    step();
    @(negedge clock);
    nChecks++;
    if ({bus.wb_valid, bus.md_start_mult, bus.md_a, bus.md_b} !== {2'b01, 32'd4, 32'd5})
      $display("FAIL hold_next_start: wb_valid=%b start=%b a=%0d b=%0d want 0 1 4 5",
               bus.wb_valid, bus.md_start_mult, bus.md_a, bus.md_b);
    else nPass++;
    step();
    waitWbValid(30, ok);
    nChecks++;
    if (!ok || {bus.wb_rd, bus.wb_data} !== {5'd9, 32'd20})
      $display("FAIL hold_second_retire: valid=%b rd=%0d data=%0d want 1 9 20", ok, bus.wb_rd, bus.wb_data);
    else nPass++;
    step();
    waitIdle(10, ok, wbSeen);
    step();
  endtask

  task automatic test_reset_mid_op();
    bit stray = 1'b0;
    bus.wb_accept = 1'b1;
    setIssue(1'b0, 32'd2, 32'd2, 5'd10);
    step();
    bus.issue_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b0;
    @(negedge clock);
    nChecks++;
    if ({bus.busy, bus.issue_ready, bus.wb_valid, bus.md_start_mult} !== 4'b0100)
      $display("FAIL rst_mid_op: busy/ready/wb_valid/start got %b want 0100",
               {bus.busy, bus.issue_ready, bus.wb_valid, bus.md_start_mult});
    else nPass++;
    step();
    step();
    reset = 1'b1;
    step();
    strayPulse = 1'b1;
    step();
    strayPulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.wb_valid || bus.md_start_mult || bus.md_start_div) stray = 1'b1;
      step();
    end
    nChecks++;
    if (stray !== 1'b0) $display("FAIL rst_stray_ready: activity got 1 want 0");
    else nPass++;
    @(negedge clock);
    nChecks++;
    if ({bus.busy, bus.issue_ready} !== 2'b01)
      $display("FAIL rst_after_release: busy/ready got %b want 01", {bus.busy, bus.issue_ready});
    else nPass++;
    step();
  endtask

  // Hard stop in case any wait misbehaves
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b0;
    strayPulse       = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.issue_is_div = 1'b0;
    bus.issue_a      = '0;
    bus.issue_b      = '0;
    bus.issue_rd     = '0;
    bus.chk_rs       = '0;
    bus.chk_rt       = '0;
    bus.wb_accept    = 1'b0;
    step();
    test_reset();
    test_single_mult();
    test_back_to_back();
    test_hazard();
    test_exception();
    test_hold_stable();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
